// File: rtl/cpu_sram_bridge_pkg.sv
// Shared definitions for the core-to-bus SRAM bridge: FSM state encoding,
// bus transfer size codes and the strobe-to-size decode.
package cpu_sram_bridge_pkg;

  // Bridge FSM states. Data-side states come first because data accesses
  // belong to the older instruction and are always served first.
  typedef enum logic [2:0] {
    BR_IDLE   = 3'd0,
    BR_D_REQ  = 3'd1,
    BR_D_WAIT = 3'd2,
    BR_I_REQ  = 3'd3,
    BR_I_WAIT = 3'd4
  } br_state_e;

  // Encoding of bus_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Map a byte-write-strobe pattern onto a bus transfer size. Patterns that
  // do not describe an aligned byte, half or word fall back to a word.
  function automatic logic [1:0] strb_to_size(input logic [3:0] strb);
    logic [1:0] size;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
      4'b0011, 4'b1100:                   size = SZ_HALF;
      4'b1111:                            size = SZ_WORD;
      default:                            size = SZ_WORD;
    endcase
    return size;
  endfunction

  // True for the strobe patterns the core is allowed to present
  // (0 = read, otherwise an aligned byte, half or full word).
  function automatic logic strb_is_legal(input logic [3:0] strb);
    logic legal;
    case (strb)
      4'b0000,
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100,
      4'b1111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cpu_sram_bridge.sv
// Bridge between the core's two fixed-latency SRAM ports (inst/data) and a
// single shared req/addr_ok/data_ok bus. Accesses of one core cycle are
// serialised data-first; the pipeline is stalled until all of them finish
// and read data is returned through holding registers.
module cpu_sram_bridge
  import cpu_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              stallreq_bridge,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  br_state_e         state_reg;
  logic              d_done_reg;
  logic              i_done_reg;
  logic              bus_req_reg;
  logic              d_wr_reg;
  logic [DATA_W-1:0] inst_rdata_reg;
  logic [DATA_W-1:0] data_rdata_reg;

  logic              d_pend;
  logic              i_pend;
  logic              data_side;

  // The fetch port is read-only; its write controls are deliberately unused.
  logic              unused_inst_wr;
  assign unused_inst_wr = ^{inst_sram_wen, inst_sram_wdata};

  // An access is pending while the core requests it and it has not yet
  // completed during the current (stalled) core cycle.
  assign d_pend = data_sram_en & ~d_done_reg;
  assign i_pend = inst_sram_en & ~i_done_reg;

  // Stall while a transaction is in flight or anything is still pending.
  assign stallreq_bridge = (state_reg != BR_IDLE) | d_pend | i_pend;

  assign bus_req         = bus_req_reg;
  assign inst_sram_rdata = inst_rdata_reg;
  assign data_sram_rdata = data_rdata_reg;

  // Control FSM: sequences one bus transaction at a time, tracks per-cycle
  // completion flags and captures returned read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= BR_IDLE;
      d_done_reg     <= 1'b0;
      i_done_reg     <= 1'b0;
      bus_req_reg    <= 1'b0;
      d_wr_reg       <= 1'b0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      case (state_reg)
        BR_IDLE: begin
          if (d_pend) begin
            state_reg   <= BR_D_REQ;
            bus_req_reg <= 1'b1;
          end else if (i_pend) begin
            state_reg   <= BR_I_REQ;
            bus_req_reg <= 1'b1;
          end else begin
            // Core advances on this edge: start the next cycle afresh.
            d_done_reg <= 1'b0;
            i_done_reg <= 1'b0;
          end
        end

        BR_D_REQ: begin
          if (bus_addr_ok) begin
            state_reg   <= BR_D_WAIT;
            bus_req_reg <= 1'b0;
            // Remember read/write so the response is handled correctly even
            // if the core misbehaves and drops its request mid-flight.
            d_wr_reg    <= |data_sram_wen;
          end
        end

        BR_D_WAIT: begin
          if (bus_data_ok) begin
            if (!d_wr_reg) begin
              data_rdata_reg <= bus_rdata;
            end
            d_done_reg <= 1'b1;
            state_reg  <= BR_IDLE;
          end
        end

        BR_I_REQ: begin
          if (bus_addr_ok) begin
            state_reg   <= BR_I_WAIT;
            bus_req_reg <= 1'b0;
          end
        end

        BR_I_WAIT: begin
          if (bus_data_ok) begin
            inst_rdata_reg <= bus_rdata;
            i_done_reg     <= 1'b1;
            state_reg      <= BR_IDLE;
          end
        end

        default: begin
          state_reg   <= BR_IDLE;
          bus_req_reg <= 1'b0;
        end
      endcase
    end
  end

  // Request payload mux: the core holds its inputs stable while stalled, so
  // the bus fields are driven straight from whichever port owns the bus.
  always_comb begin
    data_side = (state_reg == BR_D_REQ) || (state_reg == BR_D_WAIT);
    bus_addr  = inst_sram_addr;
    bus_wr    = 1'b0;
    bus_wstrb = 4'b0000;
    bus_size  = SZ_WORD;
    bus_wdata = '0;
    if (data_side) begin
      bus_addr  = data_sram_addr;
      bus_wr    = |data_sram_wen;
      bus_wstrb = data_sram_wen;
      bus_size  = (data_sram_wen == 4'b0000) ? SZ_WORD : strb_to_size(data_sram_wen);
      bus_wdata = data_sram_wdata;
    end
  end

  // Only aligned byte/half/word strobe patterns may reach the bus.
  a_wen_legal : assert property (@(posedge clk) disable iff (rst)
    (state_reg == BR_D_REQ) |-> strb_is_legal(data_sram_wen));

  // The core must keep requesting until its transaction has completed.
  a_data_en_held : assert property (@(posedge clk) disable iff (rst)
    ((state_reg == BR_D_REQ) || (state_reg == BR_D_WAIT)) |-> data_sram_en);

  a_inst_en_held : assert property (@(posedge clk) disable iff (rst)
    ((state_reg == BR_I_REQ) || (state_reg == BR_I_WAIT)) |-> inst_sram_en);

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Self-checking bench for cpu_sram_bridge: a transaction-level core model
// presents one instruction's accesses at a time, a bus slave model with
// random latencies answers them, and the expected bus request order, stall
// duration and returned read data are derived from the access list alone.
module tb_cpu_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_bridge;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  cpu_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq_bridge (stallreq_bridge),
    .bus_req         (bus_req),
    .bus_wr          (bus_wr),
    .bus_size        (bus_size),
    .bus_wstrb       (bus_wstrb),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_addr_ok     (bus_addr_ok),
    .bus_data_ok     (bus_data_ok),
    .bus_rdata       (bus_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = fetch, 1 = data read, 2 = data write
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          kind;
  } req_t;

  req_t        exp_q[$];
  req_t        hs_log[$];
  logic [31:0] val_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;

  // expected architectural state
  logic [31:0] exp_i = 32'h0;
  logic [31:0] exp_d = 32'h0;

  // slave model state
  bit          sl_busy  = 0;
  bit          a_chosen = 0;
  int          a_left, a_total, d_left, sl_kind;
  logic [31:0] sl_val;
  int          forced_a = -1;
  int          forced_d = -1;
  bit          spur_en  = 0;

  // per-instruction observation
  bit          cur_stall;
  logic [31:0] cur_i, cur_d;
  int          stall_cnt, req_cnt, exp_stall, exp_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfer size from the strobes: one byte lane -> byte, two -> half,
  // anything else (full word, or a read) -> word.
  function automatic logic [1:0] spec_size(input logic [3:0] wen);
    if (wen == 4'b0000)           return 2'd2;
    else if ($countones(wen) == 1) return 2'd0;
    else if ($countones(wen) == 2) return 2'd1;
    else                           return 2'd2;
  endfunction

  // One clock cycle: sample/compare at negedge, act as bus slave, then move
  // to just after the next rising edge.
  task automatic tick();
    req_t e;
    req_t h;
    @(negedge clk);
    cur_stall = stallreq_bridge;
    cur_i     = inst_sram_rdata;
    cur_d     = data_sram_rdata;
    if (cur_stall) stall_cnt++;
    if (bus_req)   req_cnt++;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom;
    if (sl_busy) begin
      chk("single_outstanding", {31'b0, bus_req}, 32'h0);
      if (d_left == 0) begin
        bus_data_ok = 1'b1;
        bus_rdata   = sl_val;
        sl_busy     = 0;
        if (sl_kind == 0)      exp_i = sl_val;
        else if (sl_kind == 1) exp_d = sl_val;
      end else begin
        d_left--;
      end
    end else if (bus_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", {31'b0, bus_req}, 32'h0);
      end else begin
        e = exp_q[0];
        chk("bus_addr",  bus_addr,  e.addr);
        chk("bus_wr",    {31'b0, bus_wr}, {31'b0, e.wr});
        chk("bus_size",  {30'b0, bus_size}, {30'b0, e.size});
        chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, e.wstrb});
        if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
        if (!a_chosen) begin
          a_left   = (forced_a >= 0) ? forced_a : $urandom_range(0, 3);
          a_total  = a_left;
          a_chosen = 1;
        end
        if (a_left == 0) begin
          bus_addr_ok = 1'b1;
          void'(exp_q.pop_front());
          h.addr = bus_addr; h.wr = bus_wr; h.size = bus_size;
          h.wstrb = bus_wstrb; h.wdata = bus_wdata; h.kind = e.kind;
          hs_log.push_back(h);
          a_chosen  = 0;
          sl_busy   = 1;
          sl_kind   = e.kind;
          d_left    = (forced_d >= 0) ? forced_d : $urandom_range(0, 3);
          sl_val    = (val_q.size() != 0) ? val_q.pop_front() : $urandom;
          exp_stall += 3 + a_total + d_left;
          exp_req   += 1 + a_total;
        end else begin
          a_left--;
        end
      end
    end
    if (!sl_busy && !bus_addr_ok && !bus_data_ok && spur_en && ($urandom_range(0, 3) == 0)) begin
      bus_data_ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Present one core cycle's accesses and run until the stall releases.
  task automatic run_instr(input bit ien, input logic [31:0] iaddr,
                           input bit den, input logic [3:0] wen,
                           input logic [31:0] daddr, input logic [31:0] wdata);
    req_t e;
    bit   done = 0;
    inst_sram_en    = ien;
    inst_sram_addr  = iaddr;
    inst_sram_wen   = 4'($urandom);
    inst_sram_wdata = $urandom;
    data_sram_en    = den;
    data_sram_wen   = wen;
    data_sram_addr  = daddr;
    data_sram_wdata = wdata;
    exp_q.delete();
    hs_log.delete();
    if (den) begin
      e.addr = daddr; e.wr = (wen != 0); e.size = spec_size(wen);
      e.wstrb = wen; e.wdata = wdata; e.kind = (wen != 0) ? 2 : 1;
      exp_q.push_back(e);
    end
    if (ien) begin
      e.addr = iaddr; e.wr = 1'b0; e.size = 2'd2;
      e.wstrb = 4'b0000; e.wdata = 32'h0; e.kind = 0;
      exp_q.push_back(e);
    end
    stall_cnt = 0; req_cnt = 0; exp_stall = 0; exp_req = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!cur_stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: stall still high after 400 cycles, expected release");
      finish_run();
    end
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("stall_cycles",  stall_cnt, exp_stall);
    chk("req_cycles",    req_cnt,   exp_req);
    chk("inst_rdata",    cur_i,     exp_i);
    chk("data_rdata",    cur_d,     exp_d);
    $display("txn i=%0b@%h d=%0b wen=%b @%h stall=%0d irdata=%h drdata=%h",
             ien, iaddr, den, wen, daddr, stall_cnt, cur_i, cur_d);
  endtask

  logic [3:0] wen_tbl[8];

  initial begin
    wen_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_bus_req", {31'b0, bus_req}, 32'h0);
    chk("reset_stall",   {31'b0, stallreq_bridge}, 32'h0);
    chk("reset_irdata",  inst_sram_rdata, 32'h0);
    chk("reset_drdata",  data_sram_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch only: addr_ok same cycle, data_ok two cycles after it.
    forced_a = 0; forced_d = 1;
    val_q.push_back(32'h3C1D0001);
    run_instr(1, 32'hBFC00000, 0, 4'b0000, 32'h0, 32'h0);
    chk("t1_stall4",   stall_cnt, 32'd4);
    chk("t1_req1",     req_cnt,   32'd1);
    chk("t1_irdata",   cur_i,     32'h3C1D0001);
    chk("t1_size",     {30'b0, hs_log[0].size}, 32'd2);

    // Fetch and load together: data goes first.
    forced_a = 0; forced_d = 0;
    val_q.push_back(32'h12345678);
    val_q.push_back(32'h8C020000);
    run_instr(1, 32'hBFC00004, 1, 4'b0000, 32'h80000010, 32'h0);
    chk("t2_first_addr",  hs_log[0].addr, 32'h80000010);
    chk("t2_first_wr",    {31'b0, hs_log[0].wr}, 32'h0);
    chk("t2_second_addr", hs_log[1].addr, 32'hBFC00004);
    chk("t2_stall6",      stall_cnt, 32'd6);
    chk("t2_drdata",      cur_d, 32'h12345678);
    chk("t2_irdata",      cur_i, 32'h8C020000);

    // Byte store: data read register must not change.
    run_instr(0, 32'h0, 1, 4'b0100, 32'h80000022, 32'h00AB0000);
    chk("t3_wr",     {31'b0, hs_log[0].wr}, 32'h1);
    chk("t3_size",   {30'b0, hs_log[0].size}, 32'd0);
    chk("t3_wstrb",  {28'b0, hs_log[0].wstrb}, 32'h4);
    chk("t3_wdata",  hs_log[0].wdata, 32'h00AB0000);
    chk("t3_drdata", cur_d, 32'h12345678);

    run_instr(0, 32'h0, 1, 4'b1100, 32'h80000040, 32'hBEEF0000);
    chk("t4_half_size", {30'b0, hs_log[0].size}, 32'd1);
    run_instr(0, 32'h0, 1, 4'b1111, 32'h80000044, 32'hCAFEF00D);
    chk("t4_word_size", {30'b0, hs_log[0].size}, 32'd2);

    // addr_ok withheld for 5 cycles.
    forced_a = 5; forced_d = 0;
    run_instr(1, 32'hBFC00008, 0, 4'b0000, 32'h0, 32'h0);
    chk("t5_req6",    req_cnt,   32'd6);
    chk("t5_stall8",  stall_cnt, 32'd8);
    chk("t5_one_req", hs_log.size(), 32'd1);

    // No access at all: no stall.
    run_instr(0, 32'h0, 0, 4'b0000, 32'h0, 32'h0);
    chk("t6_no_stall", stall_cnt, 32'd0);

    // Randomised instruction stream with random latencies and stray data_ok.
    forced_a = -1; forced_d = -1; spur_en = 1;
    for (int n = 0; n < 150; n++) begin
      run_instr(($urandom_range(0, 7) != 0), {$urandom_range(0, 32'h3FFF), 2'b00},
                $urandom_range(0, 1), wen_tbl[$urandom_range(0, 7)],
                32'h80000000 | $urandom_range(0, 32'hFFFF), $urandom);
    end
    spur_en = 0;

    // Reset while a load waits for its response.
    forced_a = 0; forced_d = 20;
    inst_sram_en = 0;
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80000100;
    exp_q.delete();
    begin
      req_t e;
      e.addr = 32'h80000100; e.wr = 0; e.size = 2'd2; e.wstrb = 0; e.wdata = 0; e.kind = 1;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 10 && !sl_busy; c++) tick();
    tick();
    rst = 1'b1;
    data_sram_en = 0;
    sl_busy = 0;
    exp_q.delete();
    @(negedge clk);
    bus_data_ok = 1'b0;
    bus_addr_ok = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_i = 32'h0;
    exp_d = 32'h0;
    @(negedge clk);
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_stall",   {31'b0, stallreq_bridge}, 32'h0);
    chk("rst_irdata",  inst_sram_rdata, 32'h0);
    chk("rst_drdata",  data_sram_rdata, 32'h0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("late_dok_drdata", data_sram_rdata, 32'h0);
    chk("late_dok_stall",  {31'b0, stallreq_bridge}, 32'h0);
    chk("late_dok_req",    {31'b0, bus_req}, 32'h0);
    @(posedge clk);
    #1;

    // Bridge must be fully usable again.
    forced_a = -1; forced_d = -1;
    run_instr(1, 32'hBFC00010, 1, 4'b0000, 32'h80000200, 32'h0);

    finish_run();
  end

endmodule
